serializer: RTL and testbench
=============================

# serializer

Parallel-to-serial transmitter for the USB4 logical-layer link model. It accepts `DATA_WIDTH-1` payload bits per word over a valid/ready handshake. It emits one frame per word on a single-bit line: a `0` start bit followed by the payload, MSB first, one bit per clock. The line idles at `1`. The block is the transmit end of the link whose receive end is the `deserializer`; in loopback, the deserializer's `parallel_data` equals `{1'b0, payload}`.

## Interface
- `DATA_WIDTH`, default 10: frame length in bits, start bit included. Legal range 3–32.
- `clk` in 1: clock. All state updates on its rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `in_valid` in 1: upstream word valid.
- `in_ready` out 1: block can accept a word this cycle.
- `in_data` in `DATA_WIDTH-1`: payload. Sampled when `in_valid && in_ready`.
- `out_bit` out 1: serial line, registered.
- `busy` out 1: high while a frame is on the line or a word is held.
- `frame_done` out 1: one-cycle pulse, high in the same cycle `out_bit` carries a frame's last payload bit (LSB).

## Operation
- Storage:
  - One-entry holding register: `hold_data`, `hold_full`.
  - Shift register: `shreg`, `DATA_WIDTH-1` bits.
  - Bit counter: `bit_cnt`, `$clog2(DATA_WIDTH)` bits, range 0..`DATA_WIDTH-1`.
  - State register.
- Handshake:
  - `in_ready = !hold_full` (combinational).
  - A transfer occurs on a rising edge with `in_valid && in_ready`. It sets `hold_full` and captures `hold_data`.
  - `in_valid` may drop without a transfer. Nothing is stored unless a transfer occurs.
- States: IDLE, SHIFT; GAP only when `SER_GAP_EN` is defined.
- IDLE:
  - `out_bit = 1`.
  - If `hold_full`: load `shreg <= hold_data`, clear `hold_full`, drive `out_bit <= 0` (start bit), set `bit_cnt <= 1`, go to SHIFT.
- SHIFT:
  - Each cycle: `out_bit <= shreg[MSB]`, shift `shreg` left, `bit_cnt <= bit_cnt + 1`.
  - When `bit_cnt == DATA_WIDTH-1`: the payload LSB is being driven and `frame_done` is high.
  - On that same edge, if `hold_full` (without gap), load the next word and drive the start bit. This gives back-to-back frames with zero idle bits. Otherwise go to IDLE with `out_bit <= 1`.
- Simultaneous events:
  - A transfer into an empty hold on the same edge that the shifter loads from hold is impossible, because `in_ready` is low whenever hold is full.
  - The edge after a load, `in_ready` is high again.
- Reset (async, any time, including mid-frame):
  - `out_bit = 1`, `in_ready = 1`, `busy = 0`, `frame_done = 0`, `hold_full = 0`, `bit_cnt = 0`, state IDLE.
  - A partial frame is abandoned and the held word is discarded.
  - After reset release, the first frame starts only from a new transfer.
- `busy = hold_full || (state != IDLE)`.

## Timing
- Latency:
  - Transfer at edge N → `hold_full` set.
  - Edge N+1 → start bit on `out_bit`.
  - Payload MSB after edge N+2; payload LSB after edge N+`DATA_WIDTH`.
- Frame occupies exactly `DATA_WIDTH` consecutive cycles on `out_bit`.
- Sustained throughput: one word per `DATA_WIDTH` cycles when upstream keeps `in_valid` high.
  - `in_ready` is high for one cycle after each load.
  - `in_ready` is low while the next word waits.
- `frame_done` is registered and aligned to the LSB cycle, not to the following cycle.

## Configuration
- `SER_GAP_EN` undefined:
  - Frames are back-to-back when a word is held at the LSB cycle. This matches the deserializer's immediate re-arm at counter 0.
- `SER_GAP_EN` defined:
  - After each LSB, the FSM enters GAP for exactly one cycle with `out_bit = 1`, then follows the IDLE rules.
  - Minimum frame spacing is `DATA_WIDTH+1` cycles.
  - `busy` stays high during GAP.
  - Reset behaviour is unchanged.

## Test plan
- Single frame, `DATA_WIDTH=10`:
  - Stimulus: `in_data=9'h1A5` transferred at edge 0.
  - Response: `out_bit` from edge 1 onward is `0,1,1,0,1,0,0,1,0,1`, then `1` idle; `frame_done` high only on the 10th bit.
- Back-to-back:
  - Stimulus: words `9'h000`, `9'h1FF`, `9'h0AA` with `in_valid` held high.
  - Response: 30 consecutive frame bits with no idle `1` between frames; `in_ready` pulses once per frame.
- Backpressure:
  - Stimulus: `in_valid` high while `hold_full`.
  - Response: `in_ready=0`, no capture; `in_data` changes during the stall do not corrupt the held word.
- Loopback:
  - Stimulus: `out_bit` drives the deserializer `in_bit`; send 100 random payloads.
  - Response: each `parallel_data` equals `{1'b0, payload}` in order.
- Reset mid-frame:
  - Stimulus: assert `rst` during bit 4 with a word held.
  - Response: `out_bit=1` asynchronously, `busy=0`, `in_ready=1`; no frame after release until a new transfer.
- `SER_GAP_EN` build:
  - Stimulus: the back-to-back case.
  - Response: exactly one `1` between frames; frame period 11 cycles.

Source files
------------

// File: rtl/serializer.sv
// Parallel-to-serial frame transmitter: a 0 start bit, then the payload MSB first; the line idles at 1.
// Define SER_GAP_EN to insert one idle bit after every frame.
module serializer #(
    parameter int unsigned DATA_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-2:0] in_data,
    output logic                  out_bit,
    output logic                  busy,
    output logic                  frame_done
);

    localparam int unsigned PAY_W = DATA_WIDTH - 1;
    localparam int unsigned CNT_W = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_WIDTH - 1);

`ifdef SER_GAP_EN
    typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;
`else
    typedef enum logic {IDLE, SHIFT} state_t;
`endif

    state_t           state;
    logic [PAY_W-1:0] hold_data;
    logic             hold_full;
    logic [PAY_W-1:0] shreg;
    logic [CNT_W-1:0] bit_cnt;
    logic             start_c;

    assign in_ready = !hold_full;
    assign busy     = hold_full || (state != IDLE);

    // A held word starts a frame from IDLE, or right after the LSB cycle (bit_cnt wrapped to 0).
    always_comb begin
        start_c = 1'b0;
        case (state)
            IDLE:  start_c = hold_full;
`ifdef SER_GAP_EN
            GAP:   start_c = hold_full;
`else
            SHIFT: start_c = hold_full && (bit_cnt == '0);
`endif
            default: start_c = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            hold_data  <= '0;
            hold_full  <= 1'b0;
            shreg      <= '0;
            bit_cnt    <= '0;
            out_bit    <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;

            if (in_valid && !hold_full) begin
                hold_full <= 1'b1;
                hold_data <= in_data;
            end

            if (start_c) begin
                shreg     <= hold_data;
                hold_full <= 1'b0;
                out_bit   <= 1'b0;
                bit_cnt   <= CNT_W'(1);
                state     <= SHIFT;
            end else begin
                case (state)
                    IDLE: out_bit <= 1'b1;
                    SHIFT: begin
                        // bit_cnt == 0 marks the cycle in which the LSB is on the line
                        if (bit_cnt == '0) begin
                            out_bit <= 1'b1;
`ifdef SER_GAP_EN
                            state   <= GAP;
`else
                            state   <= IDLE;
`endif
                        end else begin
                            out_bit    <= shreg[PAY_W-1];
                            shreg      <= {shreg[PAY_W-2:0], 1'b0};
                            frame_done <= (bit_cnt == LAST_CNT);
                            bit_cnt    <= (bit_cnt == LAST_CNT) ? '0 : bit_cnt + CNT_W'(1);
                        end
                    end
`ifdef SER_GAP_EN
                    GAP: begin
                        out_bit <= 1'b1;
                        state   <= IDLE;
                    end
`endif
                    default: begin
                        out_bit <= 1'b1;
                        state   <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_serializer.sv
// Bench for serializer: fixed frame vectors, back-to-back and reset corner cases, and random traffic
// checked cycle by cycle against a frame-schedule model plus a behavioural line receiver.
module tb_serializer;

    localparam int unsigned DW = 10;
    localparam int unsigned PW = DW - 1;
`ifdef SER_GAP_EN
    localparam int GAP = 1;
`else
    localparam int GAP = 0;
`endif

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [PW-1:0] in_data;
    logic          out_bit;
    logic          busy;
    logic          frame_done;

    serializer #(.DATA_WIDTH(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_bit    (out_bit),
        .busy       (busy),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: a word waits in a one-entry hold, then occupies the line for DW (+GAP) cycles.
    int            cyc;
    bit            m_hold;
    logic [PW-1:0] m_hold_data;
    int            line_free;
    int            m_frame_start;
    bit            exp_bit[int];
    bit            exp_fd[int];
    logic [PW-1:0] sent_q[$];
    bit            last_xfer;

    // Receiver: hunts for a 0 start bit, then collects PW bits.
    bit            rx_active;
    int            rx_n;
    logic [PW-1:0] rx_sh;
    int            n_rx;

    logic line_log[$];
    logic fd_log[$];
    logic rdy_log[$];

    typedef struct {
        logic [PW-1:0] data;
        logic [DW-1:0] frame;
    } vec_t;
    vec_t vecs[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_hold    = 1'b0;
        line_free = cyc;
        exp_bit.delete();
        exp_fd.delete();
        sent_q.delete();
        rx_active = 1'b0;
        rx_n      = 0;
    endtask

    task automatic start_frame(input logic [PW-1:0] d);
        m_frame_start = cyc;
        exp_bit[cyc] = 1'b0;
        for (int k = 1; k <= int'(PW); k++) exp_bit[cyc + k] = d[PW - k];
        exp_fd[cyc + int'(PW)] = 1'b1;
        line_free = cyc + int'(DW) + GAP;
    endtask

    task automatic sample_check();
        logic exp_o;
        exp_o = exp_bit.exists(cyc) ? exp_bit[cyc] : 1'b1;
        check("out_bit", 32'(out_bit), 32'(exp_o));
        check("frame_done", 32'(frame_done), 32'(exp_fd.exists(cyc)));
        check("in_ready", 32'(in_ready), 32'(!m_hold));
        check("busy", 32'(busy), 32'(m_hold || (cyc < line_free)));
        line_log.push_back(out_bit);
        fd_log.push_back(frame_done);
        rdy_log.push_back(in_ready);
        if (!rx_active) begin
            if (out_bit == 1'b0) begin
                rx_active = 1'b1;
                rx_n      = 0;
            end
        end else begin
            rx_sh = {rx_sh[PW-2:0], out_bit};
            rx_n++;
            if (rx_n == int'(PW)) begin
                rx_active = 1'b0;
                n_rx++;
                if (sent_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL rx_extra: got word %0h expected none (cycle %0d)", rx_sh, cyc);
                end else begin
                    check("loopback_word", 32'(rx_sh), 32'(sent_q.pop_front()));
                end
            end
        end
    endtask

    // One clock: drive, check at negedge, advance model at posedge.
    task automatic step(input logic v, input logic [PW-1:0] d);
        bit xfer;
        in_valid = v;
        in_data  = d;
        @(negedge clk);
        sample_check();
        xfer = v && !m_hold;
        @(posedge clk);
        cyc++;
        last_xfer = 1'b0;
        if (m_hold && cyc >= line_free) begin
            start_frame(m_hold_data);
            m_hold = 1'b0;
        end else if (xfer) begin
            m_hold      = 1'b1;
            m_hold_data = d;
            sent_q.push_back(d);
            last_xfer   = 1'b1;
        end
        #1;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((m_hold || cyc < line_free) && n < 60) begin
            step(1'b0, PW'($urandom));
            n++;
        end
        if (m_hold || cyc < line_free) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: idle not reached, got busy expected idle", name);
        end
    endtask

    initial begin
        logic [DW-1:0] got;
        int            fd_cnt;
        logic [PW-1:0] words[3];
        logic          exp_q[$];
        int            idx;
        int            first;
        int            bad;
        int            rises;
        int            budget;

        vecs[0] = '{data: 9'h1A5, frame: 10'b0110100101};
        vecs[1] = '{data: 9'h000, frame: 10'b0000000000};
        vecs[2] = '{data: 9'h1FF, frame: 10'b0111111111};
        vecs[3] = '{data: 9'h0AA, frame: 10'b0010101010};

        rst = 1'b0; in_valid = 1'b0; in_data = '0;
        cyc = 0; n_rx = 0; last_xfer = 1'b0; rx_sh = '0;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        check("rst_out_bit", 32'(out_bit), 32'd1);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        model_reset();

        // Single frames against fixed vectors.
        foreach (vecs[i]) begin
            line_log.delete(); fd_log.delete();
            step(1'b1, vecs[i].data);
            for (int k = 0; k < 12; k++) step(1'b0, PW'($urandom));
            got = '0;
            for (int k = 0; k < int'(DW); k++) got = {got[DW-2:0], line_log[2 + k]};
            check("vec_frame", 32'(got), 32'(vecs[i].frame));
            check("vec_idle_after", 32'(line_log[2 + DW]), 32'd1);
            fd_cnt = 0;
            foreach (fd_log[k]) fd_cnt += int'(fd_log[k]);
            check("vec_fd_count", 32'(fd_cnt), 32'd1);
            check("vec_fd_on_lsb", 32'(fd_log[1 + DW]), 32'd1);
        end

        // Back-to-back with in_valid held high.
        words[0] = 9'h000; words[1] = 9'h1FF; words[2] = 9'h0AA;
        line_log.delete(); rdy_log.delete();
        idx = 0;
        for (int k = 0; k < 40; k++) begin
            step(idx < 3, words[idx < 3 ? idx : 0]);
            if (last_xfer) idx++;
        end
        exp_q.delete();
        for (int w = 0; w < 3; w++) begin
            exp_q.push_back(1'b0);
            for (int b = int'(PW) - 1; b >= 0; b--) exp_q.push_back(words[w][b]);
            if (GAP != 0 && w < 2) exp_q.push_back(1'b1);
        end
        first = -1;
        foreach (line_log[k]) if (first < 0 && line_log[k] == 1'b0) first = k;
        bad = 0;
        foreach (exp_q[k]) if (first < 0 || line_log[first + k] !== exp_q[k]) bad++;
        check("b2b_stream_mismatches", 32'(bad), 32'd0);
        check("b2b_first_start", 32'(first), 32'd2);
        check("b2b_after_last", 32'(line_log[2 + exp_q.size()]), 32'd1);
        rises = 0;
        for (int k = 1; k < rdy_log.size(); k++) if (rdy_log[k] && !rdy_log[k-1]) rises++;
        check("b2b_ready_pulses", 32'(rises), 32'd3);
        wait_idle("b2b_idle");

        // Reset during bit 4 with a second word held.
        step(1'b1, 9'h155);
        budget = 0;
        while (!(m_hold && sent_q.size() == 2) && budget < 20) begin
            step(1'b1, 9'h0F3);
            budget++;
        end
        check("rst_mid_hold_full", 32'(m_hold), 32'd1);
        budget = 0;
        while (cyc != m_frame_start + 3 && budget < 20) begin
            step(1'b0, PW'($urandom));
            budget++;
        end
        check("rst_mid_bit4", 32'(cyc - m_frame_start), 32'd3);
        check("rst_mid_busy_before", 32'(busy), 32'd1);
        rst = 1'b0;
        #1;
        check("rst_mid_out_bit", 32'(out_bit), 32'd1);
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_in_ready", 32'(in_ready), 32'd1);
        check("rst_mid_frame_done", 32'(frame_done), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        model_reset();
        for (int k = 0; k < 15; k++) step(1'b0, PW'($urandom));

        // Random traffic, line decoded by the receiver and compared in order.
        n_rx   = 0;
        budget = 0;
        while (n_rx < 100 && budget < 4000) begin
            step(($urandom % 4) != 0, PW'($urandom));
            budget++;
        end
        check("random_words_received", 32'(n_rx >= 100), 32'd1);
        wait_idle("random_idle");
        for (int k = 0; k < int'(DW) + 2; k++) step(1'b0, PW'($urandom));
        check("random_queue_drained", 32'(sent_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
